// File: rtl/bomb_pkg.sv
// Shared types and default timing constants for the bomb slot pool.
package bomb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2
    } slot_state_t;

    localparam int FUSE_FRAMES_DEF  = 120;
    localparam int BLAST_FRAMES_DEF = 30;
    localparam int RANGE_DEF        = 2;
    localparam int TILE_W_DEF       = 4;

    typedef struct packed {
        logic [TILE_W_DEF-1:0] x;
        logic [TILE_W_DEF-1:0] y;
    } tile_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: FREE -> FUSE -> BLAST -> FREE timer FSM holding tile and owner.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int CW           = 4,
    parameter int CNTW         = 7,
    parameter int FUSE_FRAMES  = FUSE_FRAMES_DEF,
    parameter int BLAST_FRAMES = BLAST_FRAMES_DEF
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_x_i,
    input  logic [CW-1:0] load_y_i,
    input  logic          load_owner_i,
    input  logic          chain_hit_i,
    output slot_state_t   state_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          owner_o
);

    localparam logic [CNTW-1:0] FUSE_INIT  = CNTW'(FUSE_FRAMES - 1);
    localparam logic [CNTW-1:0] BLAST_INIT = CNTW'(BLAST_FRAMES - 1);

    slot_state_t     state_q;
    logic [CNTW-1:0] cnt_q;
    logic [CW-1:0]   x_q;
    logic [CW-1:0]   y_q;
    logic            owner_q;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FREE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            owner_q <= 1'b0;
        end else if (clear_i) begin
            state_q <= FREE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            owner_q <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (load_i) begin
                        state_q <= FUSE;
                        cnt_q   <= FUSE_INIT;
                        x_q     <= load_x_i;
                        y_q     <= load_y_i;
                        owner_q <= load_owner_i;
                    end
                end
                FUSE: begin
                    // A neighbouring blast preempts the remaining fuse time.
                    if (chain_hit_i || cnt_q == '0) begin
                        state_q <= BLAST;
                        cnt_q   <= BLAST_INIT;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                BLAST: begin
                    if (cnt_q == '0) begin
                        state_q <= FREE;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                default: begin
                    state_q <= FREE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign owner_o = owner_q;

endmodule

// File: rtl/bomb_scheduler.sv
// Shared bomb pool: two-player round-robin placement, per-player/per-tile limits, fuse/blast timers.
// Optional chain detonation between bombs in blast reach is enabled by defining BOMB_CHAIN_EN.
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter int NSLOT          = 4,
    parameter int CW             = 4,
    parameter int FUSE_FRAMES    = FUSE_FRAMES_DEF,
    parameter int BLAST_FRAMES   = BLAST_FRAMES_DEF,
    parameter int MAX_PER_PLAYER = 2,
    parameter int RANGE          = RANGE_DEF
) (
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic                run,
    input  logic                p0_req,
    input  logic                p1_req,
    input  logic [CW-1:0]       p0_x,
    input  logic [CW-1:0]       p0_y,
    input  logic [CW-1:0]       p1_x,
    input  logic [CW-1:0]       p1_y,
    output logic                p0_ack,
    output logic                p1_ack,
    output logic [NSLOT-1:0]    bomb_fuse,
    output logic [NSLOT-1:0]    bomb_blast,
    output logic [NSLOT-1:0]    bomb_owner,
    output logic [NSLOT*CW-1:0] bomb_x,
    output logic [NSLOT*CW-1:0] bomb_y,
    output logic                blast_any
);

    localparam int CNTW = max2(1, $clog2(max2(FUSE_FRAMES, BLAST_FRAMES)));
    localparam int SW   = max2(1, $clog2(NSLOT));
    localparam int PW   = $clog2(NSLOT + 1) + 1;

`ifdef BOMB_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    slot_state_t    st   [NSLOT];
    logic [CW-1:0]  sx   [NSLOT];
    logic [CW-1:0]  sy   [NSLOT];
    logic           sown [NSLOT];
    logic [NSLOT-1:0] load;
    logic [NSLOT-1:0] chain_hit;

    logic [PW-1:0] live_cnt0, live_cnt1;
    logic          hit0, hit1, any_free;
    logic [SW-1:0] free_idx;
    logic          elig0, elig1, gnt0, gnt1;
    logic          rr_q, rr_d;
    logic          ack0_q, ack1_q;
    logic [CW-1:0] ld_x, ld_y;

    function automatic logic near(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW-1:0] d;
        d = (a > b) ? (a - b) : (b - a);
        return int'(d) <= RANGE;
    endfunction

    // Scan from the top so the lowest-index FREE slot wins the load.
    always_comb begin
        live_cnt0 = '0;
        live_cnt1 = '0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        any_free  = 1'b0;
        free_idx  = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (st[i] == FREE) begin
                any_free = 1'b1;
                free_idx = SW'(i);
            end else begin
                if (sown[i]) live_cnt1 = live_cnt1 + PW'(1);
                else         live_cnt0 = live_cnt0 + PW'(1);
                if (sx[i] == p0_x && sy[i] == p0_y) hit0 = 1'b1;
                if (sx[i] == p1_x && sy[i] == p1_y) hit1 = 1'b1;
            end
        end
    end

    assign elig0 = run && p0_req && (live_cnt0 < PW'(MAX_PER_PLAYER)) && !hit0 && any_free;
    assign elig1 = run && p1_req && (live_cnt1 < PW'(MAX_PER_PLAYER)) && !hit1 && any_free;
    assign gnt0  = elig0 && (!elig1 || !rr_q);
    assign gnt1  = elig1 && (!elig0 || rr_q);
    assign rr_d  = (elig0 && elig1) ? !rr_q : rr_q;
    assign ld_x  = gnt1 ? p1_x : p0_x;
    assign ld_y  = gnt1 ? p1_y : p0_y;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            rr_q   <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
        end else if (!run) begin
            rr_q   <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            ack0_q <= gnt0;
            ack1_q <= gnt1;
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        assign load[g] = (gnt0 || gnt1) && (free_idx == SW'(g));

        always_comb begin
            chain_hit[g] = 1'b0;
            for (int j = 0; j < NSLOT; j++) begin
                if (j != g && st[j] == BLAST &&
                    ((sy[j] == sy[g] && near(sx[j], sx[g])) ||
                     (sx[j] == sx[g] && near(sy[j], sy[g]))))
                    chain_hit[g] = CHAIN_EN && (st[g] == FUSE);
            end
        end

        bomb_slot #(
            .CW           (CW),
            .CNTW         (CNTW),
            .FUSE_FRAMES  (FUSE_FRAMES),
            .BLAST_FRAMES (BLAST_FRAMES)
        ) u_slot (
            .frame_clk    (frame_clk),
            .Reset        (Reset),
            .clear_i      (!run),
            .load_i       (load[g]),
            .load_x_i     (ld_x),
            .load_y_i     (ld_y),
            .load_owner_i (gnt1),
            .chain_hit_i  (chain_hit[g]),
            .state_o      (st[g]),
            .x_o          (sx[g]),
            .y_o          (sy[g]),
            .owner_o      (sown[g])
        );

        assign bomb_fuse[g]          = (st[g] == FUSE);
        assign bomb_blast[g]         = (st[g] == BLAST);
        assign bomb_owner[g]         = sown[g];
        assign bomb_x[g*CW +: CW]    = sx[g];
        assign bomb_y[g*CW +: CW]    = sy[g];
    end

    assign p0_ack    = ack0_q;
    assign p1_ack    = ack1_q;
    assign blast_any = |bomb_blast;

endmodule
